microblaze_0_bram_port_arbiter: RTL

Two-master arbiter that shares the single B port of the MicroBlaze local BRAM block between two requesters, such as a DMA engine and a debug/loader master. It sits between those requesters and the BRAM block's port B signals. It decodes each address against the BRAM window and sequences one-cycle-latency BRAM accesses. It returns read data with a single-cycle acknowledge.

---
 rtl/microblaze_0_bram_port_arbiter.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/microblaze_0_bram_port_arbiter.sv
// Two-master arbiter sharing BRAM port B with one-cycle-latency accesses and a one-cycle Ack.
// Define BRAM_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise M0 has fixed priority.
//
// state  | meaning
// IDLE   | no access in flight, arbitrate any request
// ACCESS | drive BRAM port from the captured request (enable only on a window hit)
// RESP   | Ack the granted master, hand off to the other master if it is waiting
module microblaze_0_bram_port_arbiter #(
    parameter int unsigned              C_PORT_AWIDTH = 32,
    parameter int unsigned              C_PORT_DWIDTH = 32,
    parameter int unsigned              C_NUM_WE      = C_PORT_DWIDTH / 8,
    parameter logic [C_PORT_AWIDTH-1:0] C_BASEADDR    = 32'h00000000,
    parameter logic [C_PORT_AWIDTH-1:0] C_HIGHADDR    = 32'h00001FFF
) (
    input  logic                       BRAM_Clk,
    input  logic                       BRAM_Rst,

    input  logic                       M0_Req,
    input  logic [0:C_NUM_WE-1]        M0_WEN,
    input  logic [0:C_PORT_AWIDTH-1]   M0_Addr,
    input  logic [0:C_PORT_DWIDTH-1]   M0_WrData,
    output logic                       M0_Ack,
    output logic                       M0_Err,
    output logic [0:C_PORT_DWIDTH-1]   M0_RdData,

    input  logic                       M1_Req,
    input  logic [0:C_NUM_WE-1]        M1_WEN,
    input  logic [0:C_PORT_AWIDTH-1]   M1_Addr,
    input  logic [0:C_PORT_DWIDTH-1]   M1_WrData,
    output logic                       M1_Ack,
    output logic                       M1_Err,
    output logic [0:C_PORT_DWIDTH-1]   M1_RdData,

    output logic                       BRAM_EN,
    output logic [0:C_NUM_WE-1]        BRAM_WEN,
    output logic [0:C_PORT_AWIDTH-1]   BRAM_Addr,
    output logic [0:C_PORT_DWIDTH-1]   BRAM_Dout,
    input  logic [0:C_PORT_DWIDTH-1]   BRAM_Din
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // Offset-from-base compare: one unsigned subtract covers both bounds without wrap issues.
    localparam logic [C_PORT_AWIDTH-1:0] WIN_SPAN = C_HIGHADDR - C_BASEADDR;

    state_t                     state_q, state_d;
    logic                       gnt_m1_q;
    logic [0:C_PORT_AWIDTH-1]   addr_q;
    logic [0:C_NUM_WE-1]        wen_q;
    logic [0:C_PORT_DWIDTH-1]   wdata_q;
    logic                       hit_q;

    logic                       cap;
    logic                       cap_m1;
    logic                       tie_m1;
    logic [0:C_PORT_AWIDTH-1]   sel_addr;
    logic [0:C_NUM_WE-1]        sel_wen;
    logic [0:C_PORT_DWIDTH-1]   sel_wdata;
    logic [C_PORT_AWIDTH-1:0]   sel_offset;
    logic                       in_access;
    logic                       in_resp;
    logic [0:C_PORT_DWIDTH-1]   rd_data;

    // gnt_m1_q doubles as the last-grant pointer; its reset value of M1 lets M0 win the first tie.
`ifdef BRAM_ARB_ROUND_ROBIN_EN
    assign tie_m1 = M1_Req && (!M0_Req || !gnt_m1_q);
`else
    assign tie_m1 = M1_Req && !M0_Req;
`endif

    always_comb begin
        state_d = state_q;
        cap     = 1'b0;
        cap_m1  = 1'b0;
        case (state_q)
            IDLE: begin
                if (M0_Req || M1_Req) begin
                    cap     = 1'b1;
                    cap_m1  = tie_m1;
                    state_d = ACCESS;
                end
            end
            ACCESS: state_d = RESP;
            RESP: begin
                state_d = IDLE;
`ifdef BRAM_ARB_ROUND_ROBIN_EN
                if (gnt_m1_q ? M0_Req : M1_Req) begin
                    cap     = 1'b1;
                    cap_m1  = !gnt_m1_q;
                    state_d = ACCESS;
                end
`else
                // Only a waiting M0 takes the handoff; after M0 the re-arbitration in IDLE favours M0 again.
                if (gnt_m1_q && M0_Req) begin
                    cap     = 1'b1;
                    cap_m1  = 1'b0;
                    state_d = ACCESS;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    assign sel_addr   = cap_m1 ? M1_Addr   : M0_Addr;
    assign sel_wen    = cap_m1 ? M1_WEN    : M0_WEN;
    assign sel_wdata  = cap_m1 ? M1_WrData : M0_WrData;
    assign sel_offset = sel_addr - C_BASEADDR;

    always_ff @(posedge BRAM_Clk) begin
        if (BRAM_Rst) begin
            state_q  <= IDLE;
            gnt_m1_q <= 1'b1;
            addr_q   <= '0;
            wen_q    <= '0;
            wdata_q  <= '0;
            hit_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (cap) begin
                gnt_m1_q <= cap_m1;
                addr_q   <= sel_addr;
                wen_q    <= sel_wen;
                wdata_q  <= sel_wdata;
                hit_q    <= (sel_offset <= WIN_SPAN);
            end
        end
    end

    assign in_access = (state_q == ACCESS);
    assign in_resp   = (state_q == RESP);

    assign BRAM_EN   = in_access && hit_q;
    assign BRAM_WEN  = (in_access && hit_q) ? wen_q : '0;
    assign BRAM_Addr = in_access ? addr_q  : '0;
    assign BRAM_Dout = in_access ? wdata_q : '0;

    // BRAM_Din is the block's registered output, valid in the cycle after the enable.
    assign rd_data = (in_resp && hit_q && (wen_q == '0)) ? BRAM_Din : '0;

    assign M0_Ack    = in_resp && !gnt_m1_q;
    assign M1_Ack    = in_resp &&  gnt_m1_q;
    assign M0_Err    = M0_Ack && !hit_q;
    assign M1_Err    = M1_Ack && !hit_q;
    assign M0_RdData = gnt_m1_q ? '0 : rd_data;
    assign M1_RdData = gnt_m1_q ? rd_data : '0;

endmodule
